// File: rtl/gate_tt_checker.sv
// gate_tt_checker: drives every input vector to a small combinational gate, samples its response
// after a settle window and checks it against a programmable truth table. Optional: STOP_ON_FAIL_EN.
module gate_tt_checker #(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_CNT_W     = N_INPUTS + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2**N_INPUTS-1:0]   expected_tt,
  output logic [N_INPUTS-1:0]      dut_in,
  input  logic                     dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic [N_INPUTS-1:0]      first_fail_idx,
  output logic                     first_fail_valid
);

  localparam int unsigned CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      settle_cnt, settle_cnt_d;
  logic [N_INPUTS-1:0]   dut_in_d;
  logic                  busy_d, done_d, pass_d;
  logic [ERR_CNT_W-1:0]  err_count_d;
  logic [N_INPUTS-1:0]   first_fail_idx_d;
  logic                  first_fail_valid_d;
  logic                  mismatch;
  logic                  last_vec;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      settle_cnt       <= '0;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_d;
      settle_cnt       <= settle_cnt_d;
      dut_in           <= dut_in_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      err_count        <= err_count_d;
      first_fail_idx   <= first_fail_idx_d;
      first_fail_valid <= first_fail_valid_d;
    end
  end

  // Next-state and next-output logic; dut_in doubles as the vector index
  always_comb begin
    state_d            = state;
    settle_cnt_d       = settle_cnt;
    dut_in_d           = dut_in;
    busy_d             = busy;
    done_d             = 1'b0;
    pass_d             = pass;
    err_count_d        = err_count;
    first_fail_idx_d   = first_fail_idx;
    first_fail_valid_d = first_fail_valid;
    mismatch           = dut_out ^ expected_tt[dut_in];
    last_vec           = &dut_in;

    case (state)
      S_IDLE: begin
        if (start) begin
          dut_in_d           = '0;
          settle_cnt_d       = '0;
          err_count_d        = '0;
          first_fail_valid_d = 1'b0;
          pass_d             = 1'b0;
          busy_d             = 1'b1;
          state_d            = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == LAST_CNT) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt + CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        if (mismatch) begin
          if (err_count != {ERR_CNT_W{1'b1}}) begin
            err_count_d = err_count + ERR_CNT_W'(1);
          end
          if (!first_fail_valid) begin
            first_fail_idx_d   = dut_in;
            first_fail_valid_d = 1'b1;
          end
        end
`ifdef STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
          state_d = S_DONE;
        end else begin
          dut_in_d     = dut_in + N_INPUTS'(1);
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
`else
        if (last_vec) begin
          state_d = S_DONE;
        end else begin
          dut_in_d     = dut_in + N_INPUTS'(1);
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
`endif
      end

      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_count == '0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
